// File: rtl/rr_arb_4_if.sv
// Request/grant bundle between the requesters, the round-robin arbiter and the
// downstream 4-to-2 encoder consumer.
interface rr_arb_4_if;
    logic [3:0] req;
    logic       out_ready;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       stall_err;

    modport slave (
        input  req,
        input  out_ready,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output stall_err
    );

    modport master (
        output req,
        output out_ready,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  stall_err
    );
endinterface

// File: rtl/rr_arb_4.sv
// Registered 4-way round-robin arbiter: strictly one-hot grant plus encoded index,
// held until accepted, with a sticky backpressure-timeout flag.
module rr_arb_4 #(
    parameter logic [1:0] PTR_INIT  = 2'd3,
    parameter int         STALL_MAX = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arb_4_if.slave    bus
);

    localparam logic [7:0] STALL_LIM = 8'(STALL_MAX);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [3:0] r_gnt;
    logic [1:0] r_idx;
    logic       r_valid;
    logic [7:0] r_stall_cnt;
    logic       r_stall_err;

    // Returns {found, index}: first set request searching ptr+1 .. ptr+4 (mod 4).
    function automatic logic [2:0] f_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    // The handshake path searches from the index being accepted, which becomes the new ptr.
    logic [2:0] w_pick_idle;
    logic [2:0] w_pick_hs;
    logic       w_stall_inc;

    assign w_pick_idle = f_pick(bus.req, r_ptr);
    assign w_pick_hs   = f_pick(bus.req, r_idx);
    assign w_stall_inc = (r_stall_cnt < STALL_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= PTR_INIT;
            r_gnt       <= 4'b0000;
            r_idx       <= 2'd0;
            r_valid     <= 1'b0;
            r_stall_cnt <= 8'd0;
            r_stall_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_stall_cnt <= 8'd0;
                    if (w_pick_idle[2]) begin
                        r_state <= S_GRANT;
                        r_gnt   <= 4'b0001 << w_pick_idle[1:0];
                        r_idx   <= w_pick_idle[1:0];
                        r_valid <= 1'b1;
                    end
                end
                S_GRANT: begin
                    if (bus.out_ready) begin
                        r_ptr       <= r_idx;
                        r_stall_cnt <= 8'd0;
                        if (w_pick_hs[2]) begin
                            r_gnt <= 4'b0001 << w_pick_hs[1:0];
                            r_idx <= w_pick_hs[1:0];
                        end else begin
                            r_state <= S_IDLE;
                            r_gnt   <= 4'b0000;
                            r_idx   <= 2'd0;
                            r_valid <= 1'b0;
                        end
                    end else if (w_stall_inc) begin
                        // Counter saturates at the limit; the flag is sticky until reset.
                        r_stall_cnt <= r_stall_cnt + 8'd1;
                        if (r_stall_cnt + 8'd1 == STALL_LIM) begin
                            r_stall_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= 4'b0000;
                    r_idx   <= 2'd0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_idx   = r_idx;
    assign bus.gnt_valid = r_valid;
    assign bus.stall_err = r_stall_err;

endmodule
